// File: rtl/lib_arbiter_pkg.sv
// Shared defaults, derived-width helpers and FSM state type for the AER
// hierarchical arbiter and its event FIFO.
package lib_arbiter_pkg;

    localparam int unsigned DEF_ROWS       = 8;
    localparam int unsigned DEF_COLS       = 8;
    localparam int unsigned DEF_GRP_ROWS   = 4;
    localparam int unsigned DEF_GRP_COLS   = 4;
    localparam int unsigned DEF_TS_W       = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Address width for n items; a single item still needs one bit of storage.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Event word: {row, col, timestamp, polarity}.
    function automatic int unsigned evt_width(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned ts_w);
        return addr_w(rows) + addr_w(cols) + ts_w + 1;
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// First-word-fall-through event FIFO.
// Ports: clk_i/reset_i (sync, active-high), push_i/data_i write side (ignored
// when full), pop_i read strobe (ignored when empty), valid_o/data_o head of
// queue (data_o is zero while empty), count_o occupancy.
module aer_event_fifo
    import lib_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = evt_width(DEF_ROWS, DEF_COLS, DEF_TS_W),
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/aer_hier_arbiter.sv
// Two-level AER arbiter: round-robin over pixel groups, then row-major service
// of a snapshot of the chosen group's requests, one pixel per cycle.
// Ports: clk_i/reset_i (sync, active-high), en_i gates new group entry,
// req_i per-pixel 2-bit request, gnt_o one-hot registered grant,
// grp_release_o end-of-group pulse, evt_* FWFT event stream and occupancy.
module aer_hier_arbiter
    import lib_arbiter_pkg::*;
#(
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned GRP_ROWS   = DEF_GRP_ROWS,
    parameter int unsigned GRP_COLS   = DEF_GRP_COLS,
    parameter int unsigned TS_W       = DEF_TS_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned ROW_ADD   = addr_w(ROWS),
    localparam int unsigned COL_ADD   = addr_w(COLS),
    localparam int unsigned WIDTH     = evt_width(ROWS, COLS, TS_W),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            en_i,
    input  logic [ROWS-1:0][COLS-1:0][1:0]  req_i,
    output logic [ROWS-1:0][COLS-1:0]       gnt_o,
    output logic                            grp_release_o,
    output logic                            evt_valid_o,
    input  logic                            evt_ready_i,
    output logic [WIDTH-1:0]                evt_data_o,
    output logic [CNT_W-1:0]                evt_count_o
);

    localparam int unsigned GRP_PER_ROW = COLS / GRP_COLS;
    localparam int unsigned NUM_GRP     = (ROWS / GRP_ROWS) * GRP_PER_ROW;
    localparam int unsigned GRP_SZ      = GRP_ROWS * GRP_COLS;
    localparam int unsigned GRP_W       = addr_w(NUM_GRP);
    localparam int unsigned LOC_W       = addr_w(GRP_SZ);

    arb_state_e                 state_q, state_d;
    logic [GRP_W-1:0]           ptr_q, ptr_d;
    logic [GRP_W-1:0]           sel_grp_q, sel_grp_d;
    logic [GRP_SZ-1:0]          snap_q, snap_d;
    logic [TS_W-1:0]            ts_q;
    logic [ROWS-1:0][COLS-1:0]  gnt_q, gnt_d;
    logic                       release_q, release_d;

    logic [NUM_GRP-1:0][GRP_SZ-1:0] grp_mask;
    logic [NUM_GRP-1:0]             grp_pend;
    logic                           sel_found;
    logic [GRP_W-1:0]               sel_idx;
    logic [LOC_W-1:0]               loc;
    logic [ROW_ADD-1:0]             pix_x;
    logic [COL_ADD-1:0]             pix_y;
    logic [1:0]                     pix_req;
    logic                           fifo_full;
    logic                           push_c;
    logic [WIDTH-1:0]               push_data;

    // Per-group request masks; member k sits at local row k/GRP_COLS, col k%GRP_COLS.
    always_comb begin
        grp_mask = '0;
        grp_pend = '0;
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            for (int unsigned k = 0; k < GRP_SZ; k++) begin
                grp_mask[GRP_W'(g)][LOC_W'(k)] =
                    req_i[ROW_ADD'((g / GRP_PER_ROW) * GRP_ROWS + k / GRP_COLS)]
                         [COL_ADD'((g % GRP_PER_ROW) * GRP_COLS + k % GRP_COLS)] != 2'b00;
            end
            grp_pend[GRP_W'(g)] = |grp_mask[GRP_W'(g)];
        end
    end

    // First pending group at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_GRP; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_GRP) begin
                cand = cand - NUM_GRP;
            end
            if (!sel_found && grp_pend[GRP_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = GRP_W'(cand);
            end
        end
    end

    // Lowest remaining snapshot member and its pixel coordinates.
    always_comb begin
        logic found;
        found = 1'b0;
        loc   = '0;
        for (int unsigned k = 0; k < GRP_SZ; k++) begin
            if (!found && snap_q[LOC_W'(k)]) begin
                found = 1'b1;
                loc   = LOC_W'(k);
            end
        end
        pix_x   = ROW_ADD'((32'(sel_grp_q) / GRP_PER_ROW) * GRP_ROWS + 32'(loc) / GRP_COLS);
        pix_y   = COL_ADD'((32'(sel_grp_q) % GRP_PER_ROW) * GRP_COLS + 32'(loc) % GRP_COLS);
        pix_req = req_i[pix_x][pix_y];
    end

    assign fifo_full = (evt_count_o == CNT_W'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (en_i && sel_found) state_d = ST_SERVE;
            ST_SERVE:   if (snap_q == '0)      state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; a full FIFO freezes the snapshot.
    always_comb begin
        snap_d    = snap_q;
        sel_grp_d = sel_grp_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        release_d = 1'b0;
        push_c    = 1'b0;
        push_data = {pix_x, pix_y, ts_q, pix_req != 2'b10};
        case (state_q)
            ST_IDLE: begin
                if (en_i && sel_found) begin
                    snap_d    = grp_mask[sel_idx];
                    sel_grp_d = sel_idx;
                end
            end
            ST_SERVE: begin
                if (snap_q == '0) begin
                    release_d = 1'b1;
                end else if (!fifo_full) begin
                    snap_d[loc] = 1'b0;
                    // A member that dropped its request is skipped silently.
                    if (pix_req != 2'b00) begin
                        gnt_d[pix_x][pix_y] = 1'b1;
                        push_c              = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                ptr_d = (32'(sel_grp_q) == NUM_GRP - 1) ? '0 : sel_grp_q + GRP_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q     <= '0;
            sel_grp_q <= '0;
            snap_q    <= '0;
            ts_q      <= '0;
            gnt_q     <= '0;
            release_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_grp_q <= sel_grp_d;
            snap_q    <= snap_d;
            ts_q      <= ts_q + TS_W'(1);
            gnt_q     <= gnt_d;
            release_q <= release_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign grp_release_o = release_q;

    aer_event_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_c),
        .data_i  (push_data),
        .pop_i   (evt_ready_i),
        .valid_o (evt_valid_o),
        .data_o  (evt_data_o),
        .count_o (evt_count_o)
    );

endmodule

// File: doc/aer_hier_arbiter.md
AER_HIER_ARBITER -- requirements
Module: aer_hier_arbiter

Interface
REQ-001 Parameter ROWS, default 8, pixel-array rows.
REQ-002 Parameter COLS, default 8, pixel-array columns.
REQ-003 Parameter GRP_ROWS, default 4, pixel rows per group; SHALL divide ROWS.
REQ-004 Parameter GRP_COLS, default 4, pixel columns per group; SHALL divide COLS.
REQ-005 Parameter TS_W, default 16, timestamp width.
REQ-006 Parameter FIFO_DEPTH, default 8, event FIFO depth; SHALL be a power of 2, >=2.
REQ-007 Derived widths: ROW_ADD=clog2(ROWS), COL_ADD=clog2(COLS), WIDTH=ROW_ADD+COL_ADD+TS_W+1.
REQ-008 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-009 reset_i  in  1  synchronous, active-high reset.
REQ-010 en_i  in  1  arbitration enable; low blocks new group entry only.
REQ-011 req_i  in  [ROWS][COLS][2]  per-pixel request: 00 none, 01 ON, 10 OFF, 11 ON.
REQ-012 gnt_o  out  [ROWS][COLS]  one-hot single-cycle pixel grant.
REQ-013 grp_release_o  out  1  one-cycle pulse when a group is fully served.
REQ-014 evt_valid_o  out  1  FIFO non-empty.
REQ-015 evt_ready_i  in  1  consumer accepts evt_data_o when high with evt_valid_o.
REQ-016 evt_data_o  out  WIDTH  {x[ROW_ADD], y[COL_ADD], timestamp[TS_W], polarity}, FIFO head.
REQ-017 evt_count_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-018 Groups indexed row-major g = (x/GRP_ROWS)*(COLS/GRP_COLS) + y/GRP_COLS; group pending when any member req_i != 00.
REQ-019 FSM states IDLE, SERVE, RELEASE; reset state IDLE.
REQ-020 IDLE: on edge with en_i=1 and any group pending, select first pending group at or after round-robin pointer (wrapping), latch its pending mask as snapshot, go SERVE.
REQ-021 SERVE: on each edge with snapshot != 0 and evt_count_o < FIFO_DEPTH, grant lowest row-major snapshot pixel, clear its snapshot bit, push its event.
REQ-022 gnt_o bit SHALL be high exactly the cycle after the granting edge; all other cycles zero.
REQ-023 Event timestamp = free-running counter value in the granting cycle; polarity 1 for req 01/11, 0 for 10, sampled at the granting edge.
REQ-024 Requests arising in the active group after snapshot are not served until that group's next visit.
REQ-025 Snapshot pixel whose req_i is 00 at its granting edge SHALL be skipped (bit cleared, no grant, no push).
REQ-026 FIFO full: SERVE stalls, snapshot held, no grant; resumes on the edge after a pop frees space.
REQ-027 Snapshot empty in SERVE: go RELEASE; RELEASE drives grp_release_o=1 for one cycle, pointer = selected group+1 mod group count, return IDLE.
REQ-028 en_i low during SERVE/RELEASE does not abort the current group.
REQ-029 Timestamp counter increments every cycle, wraps 2^TS_W-1 -> 0.
REQ-030 FIFO: pop on evt_valid_o & evt_ready_i; simultaneous push and pop keeps count; push-to-valid latency one cycle; evt_data_o first-word-fall-through.
REQ-031 Pop when empty and push when full SHALL never corrupt state (ignored).

Reset
REQ-032 reset_i=1 at an edge: state IDLE, pointer 0, snapshot 0, timestamp 0, FIFO emptied.
REQ-033 Outputs during/after reset: gnt_o 0, grp_release_o 0, evt_valid_o 0, evt_count_o 0, evt_data_o 0.
REQ-034 Reset mid-SERVE discards snapshot and queued events; no grant in cycle after reset.

Structure
REQ-035 Defaults, derived widths and FSM state enum SHALL live in lib_arbiter_pkg.
REQ-036 FIFO SHALL be sub-module aer_event_fifo (params WIDTH, FIFO_DEPTH); remainder in aer_hier_arbiter.

Verification
REQ-037 Single req_i[2][5]=01 after reset: gnt_o[2][5] one cycle, event x=2,y=5,pol=1, grp_release_o pulse, group 1 served.
REQ-038 Pixels (0,0)=10,(0,1)=01,(1,0)=01 simultaneously: grants consecutive cycles in order (0,0),(0,1),(1,0), polarities 0,1,1, timestamps +1 apart, one release.
REQ-039 Pixels (0,0) and (7,7) held constantly: groups alternate 0,3,0,3; neither starved.
REQ-040 evt_ready_i=0, 10 pending pixels in one group: exactly 8 grants, count=8, stall; ready=1 for 2 cycles -> 2 more grants, release.
REQ-041 Reset asserted between 2nd and 3rd grant of 4: no further grants, evt_valid_o=0, timestamp restarts 0.
REQ-042 TS_W=4, grant at cycle 17 after reset: timestamp field = 1 (wrap).
